// File: rtl/peso_medida_tara.sv
// Weight-measurement front end: rate-divided sampling, windowed averaging, tare and stability.
// Optional PESO_SAT_EN: clamp negative net results to zero and flag them on bajo_cero.
module peso_medida_tara #(
    parameter int unsigned WIDTH      = 13,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned STABLE_TOL = 4,
    parameter int unsigned STABLE_CNT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        peso,
    input  logic                    tara,
    input  logic                    modo,
    output logic signed [WIDTH:0]   salida_peso,
    output logic                    valido,
    output logic                    estable,
    output logic                    tara_ok,
    output logic                    bajo_cero
);

    localparam int unsigned TickW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SampW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned AccW  = WIDTH + AVG_LOG2;
    localparam int unsigned StabW = $clog2(STABLE_CNT + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(DIV - 1);
    localparam logic [SampW-1:0] SampLast = SampW'((2 ** AVG_LOG2) - 1);
    localparam logic [StabW-1:0] StabMax  = StabW'(STABLE_CNT);

    typedef enum logic [0:0] {StAcum, StTara} state_e;

    state_e             state_q, state_d;
    logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SampW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [AccW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]   tare_q, tare_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [StabW-1:0]   stab_q, stab_d;
    logic               tara_prev_q;
    logic [WIDTH:0]     salida_q, salida_d;
    logic               valido_q, estable_q, estable_d, tara_ok_q, bajo_cero_q, bajo_cero_d;

    logic               tick, window_done, tara_req, take_tare, in_tol;
    logic [AccW-1:0]    sum;
    logic [WIDTH-1:0]   avg, delta;
    logic [WIDTH:0]     net, gross;

    always_comb begin
        tick        = (tick_cnt_q == TickLast);
        window_done = tick && (samp_cnt_q == SampLast);
        sum         = acc_q + AccW'(peso);
        avg         = WIDTH'(sum >> AVG_LOG2);
        // A held tara level only raises one request.
        tara_req    = tara && !tara_prev_q;
        take_tare   = window_done && ((state_q == StTara) || tara_req);

        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        samp_cnt_d = samp_cnt_q;
        acc_d      = acc_q;
        if (window_done) begin
            samp_cnt_d = '0;
            acc_d      = '0;
        end else if (tick) begin
            samp_cnt_d = samp_cnt_q + SampW'(1);
            acc_d      = sum;
        end

        state_d = state_q;
        unique case (state_q)
            StAcum: if (tara_req && !window_done) state_d = StTara;
            StTara: if (window_done) state_d = StAcum;
            default: state_d = StAcum;
        endcase

        tare_d = take_tare ? avg : tare_q;
        net    = {1'b0, avg} - {1'b0, tare_d};
        gross  = {1'b0, avg};

        delta  = (avg >= prev_q) ? avg - prev_q : prev_q - avg;
        in_tol = (32'(delta) <= STABLE_TOL);
        if (!in_tol) begin
            stab_d = '0;
        end else if (stab_q == StabMax) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + StabW'(1);
        end
        estable_d = (stab_d == StabMax);
        prev_d    = avg;

        bajo_cero_d = 1'b0;
        if (modo) begin
`ifdef PESO_SAT_EN
            if (net[WIDTH]) begin
                salida_d    = '0;
                bajo_cero_d = 1'b1;
            end else begin
                salida_d = net;
            end
`else
            salida_d = net;
`endif
        end else begin
            salida_d = gross;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcum;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            acc_q       <= '0;
            tare_q      <= '0;
            prev_q      <= '0;
            stab_q      <= '0;
            tara_prev_q <= 1'b0;
            salida_q    <= '0;
            valido_q    <= 1'b0;
            estable_q   <= 1'b0;
            tara_ok_q   <= 1'b0;
            bajo_cero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            acc_q       <= acc_d;
            tara_prev_q <= tara;
            valido_q    <= window_done;
            tara_ok_q   <= take_tare;
            if (window_done) begin
                tare_q      <= tare_d;
                prev_q      <= prev_d;
                stab_q      <= stab_d;
                salida_q    <= salida_d;
                estable_q   <= estable_d;
                bajo_cero_q <= bajo_cero_d;
            end
        end
    end

    assign salida_peso = salida_q;
    assign valido      = valido_q;
    assign estable     = estable_q;
    assign tara_ok     = tara_ok_q;
    assign bajo_cero   = bajo_cero_q;

endmodule

// File: tb/tb_peso_medida_tara.sv
// Directed scoreboard bench for peso_medida_tara (WIDTH=13, AVG_LOG2=2, DIV=4, CNT=3).
module tb_peso_medida_tara;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [12:0]        peso = 13'd1000;
    logic               tara = 1'b0;
    logic               modo = 1'b0;
    logic signed [13:0] salida_peso;
    logic               valido, estable, tara_ok, bajo_cero;

    typedef struct {
        logic [13:0] sal;
        logic        est;
        logic        tok;
        logic        bc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    always #5 clk = ~clk;

    peso_medida_tara #(
        .WIDTH(13), .AVG_LOG2(2), .DIV(4), .STABLE_TOL(4), .STABLE_CNT(3)
    ) dut (
        .clk(clk), .rst(rst), .peso(peso), .tara(tara), .modo(modo),
        .salida_peso(salida_peso), .valido(valido), .estable(estable),
        .tara_ok(tara_ok), .bajo_cero(bajo_cero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [13:0] s, input logic e, input logic t, input logic b);
        exp_t x;
        x.sal = s; x.est = e; x.tok = t; x.bc = b;
        sb.push_back(x);
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            if (valido || c >= 64) break;
        end
        check("valido_seen", 32'(valido), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        logic [13:0] s;
        s = salida_peso;
        check({tag, "_salida"}, 32'(s), 32'd0);
        check({tag, "_valido"}, 32'(valido), 32'd0);
        check({tag, "_estable"}, 32'(estable), 32'd0);
        check({tag, "_tara_ok"}, 32'(tara_ok), 32'd0);
        check({tag, "_bajo_cero"}, 32'(bajo_cero), 32'd0);
    endtask

    // Scoreboard: each valido strobe consumes one expected window result.
    always @(negedge clk) begin
        if (!rst && valido) begin
            if (sb.size() == 0) begin
                check("unexpected_valido", 32'd1, 32'd0);
            end else begin
                exp_t x;
                logic [13:0] s;
                x = sb.pop_front();
                s = salida_peso;
                check("salida_peso", 32'(s), 32'(x.sal));
                check("estable", 32'(estable), 32'(x.est));
                check("tara_ok", 32'(tara_ok), 32'(x.tok));
                check("bajo_cero", 32'(bajo_cero), 32'(x.bc));
            end
        end
    end

    initial begin
        // 1: reset and first-window latency
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        check("first_latency", 32'(cyc), 32'd16);

        // 2: constant input, stability rises on the 4th window
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        check("window_period", 32'(cyc), 32'd16);
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1000, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);

        // 3: tare held two cycles counts once; then step to 1250 in net mode
        modo = 1'b1;
        tara = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 tara = 1'b0;
        push(14'd0, 1'b1, 1'b1, 1'b0);
        wait_valid(cyc);
        peso = 13'd1250;
        push(14'd250, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd250, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);

        // 4: below tare
        peso = 13'd900;
`ifdef PESO_SAT_EN
        push(14'd0, 1'b0, 1'b0, 1'b1);
`else
        push(14'h3F9C, 1'b0, 1'b0, 1'b0);
`endif
        wait_valid(cyc);
        modo = 1'b0;
        push(14'd900, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);

        // 5: rebuild stability at 1000, then step out of and within tolerance
        peso = 13'd1000;
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1000, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1000, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);
        peso = 13'd1005;
        push(14'd1005, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1005, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1005, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1005, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);
        peso = 13'd1008;
        push(14'd1008, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);
        // Mixed window: one sample of 1008, three of 1011 -> 4041>>2 = 1010
        repeat (5) @(posedge clk);
        #1 peso = 13'd1011;
        push(14'd1010, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);
        push(14'd1011, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);

        // Tare request landing exactly on the window-completion cycle
        modo = 1'b1;
        push(14'd0, 1'b1, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #1 tara = 1'b1;
        @(posedge clk);
        #1 tara = 1'b0;
        check("tara_on_done_valido", 32'(valido), 32'd1);
        push(14'd0, 1'b1, 1'b0, 1'b0);
        wait_valid(cyc);

        // 6: reset mid-window with a tare pending
        repeat (3) @(posedge clk);
        #1 tara = 1'b1;
        @(posedge clk);
        #1 tara = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("mid_reset");
        rst = 1'b0;
        push(14'd1011, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);
        check("reset_latency", 32'(cyc), 32'd16);
        push(14'd1011, 1'b0, 1'b0, 1'b0);
        wait_valid(cyc);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
